slab_minmax_seq: RTL



---
 rtl/slab_minmax_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/slab_minmax_seq.sv
// Ray/AABB slab finish: sequences five (six with RAY_BEHIND_CHECK_EN) compares on one shared
// pipelined FP less-than unit to form t_entry = max(tnear), t_exit = min(tfar) and hit.
module slab_minmax_seq #(
  parameter int unsigned WIDTH   = 65,
  parameter int unsigned CMP_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [WIDTH:0] tnear_x,
  input  logic [WIDTH:0] tnear_y,
  input  logic [WIDTH:0] tnear_z,
  input  logic [WIDTH:0] tfar_x,
  input  logic [WIDTH:0] tfar_y,
  input  logic [WIDTH:0] tfar_z,
  output logic           busy,
  output logic           done,
  output logic           hit,
  output logic [WIDTH:0] t_entry,
  output logic [WIDTH:0] t_exit,
  output logic [WIDTH:0] cmp_a,
  output logic [WIDTH:0] cmp_b,
  input  logic           cmp_less
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

`ifdef RAY_BEHIND_CHECK_EN
  localparam logic [2:0] LastStep = 3'd6;
`else
  localparam logic [2:0] LastStep = 3'd5;
`endif
  localparam logic [3:0] CntLast = 4'(CMP_LAT);

  state_e         state_q;
  logic [2:0]     step_q;
  logic [3:0]     cnt_q;
  logic           busy_q, done_q, hit_q;
  logic [WIDTH:0] nx_q, ny_q, nz_q, fx_q, fy_q, fz_q;
  logic [WIDTH:0] tn_q, tf_q, t_entry_q, t_exit_q, cmp_a_q, cmp_b_q;
  logic [WIDTH:0] tn_d, tf_d, cmp_a_d, cmp_b_d;
  logic           hit_fin;
`ifdef RAY_BEHIND_CHECK_EN
  logic           hit_r_q;
`endif

  // Running max/min selection and next-op operand mux, driven by the result sampled this cycle.
  always_comb begin
    tn_d    = tn_q;
    tf_d    = tf_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    case (step_q)
      3'd1: begin
        tn_d    = cmp_less ? ny_q : nx_q;
        cmp_a_d = tn_d;
        cmp_b_d = nz_q;
      end
      3'd2: begin
        tn_d    = cmp_less ? nz_q : tn_q;
        cmp_a_d = fx_q;
        cmp_b_d = fy_q;
      end
      3'd3: begin
        tf_d    = cmp_less ? fx_q : fy_q;
        cmp_a_d = fz_q;
        cmp_b_d = tf_d;
      end
      3'd4: begin
        tf_d    = cmp_less ? fz_q : tf_q;
        cmp_a_d = tn_q;
        cmp_b_d = tf_d;
      end
`ifdef RAY_BEHIND_CHECK_EN
      3'd5: begin
        cmp_a_d = tf_q;
        cmp_b_d = '0;
      end
`endif
      default: ;
    endcase
  end

`ifdef RAY_BEHIND_CHECK_EN
  // Exit behind the ray origin means no hit.
  assign hit_fin = hit_r_q & ~cmp_less;
`else
  assign hit_fin = cmp_less;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      step_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      nx_q      <= '0;
      ny_q      <= '0;
      nz_q      <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      fz_q      <= '0;
      tn_q      <= '0;
      tf_q      <= '0;
      t_entry_q <= '0;
      t_exit_q  <= '0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
`ifdef RAY_BEHIND_CHECK_EN
      hit_r_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            nx_q    <= tnear_x;
            ny_q    <= tnear_y;
            nz_q    <= tnear_z;
            fx_q    <= tfar_x;
            fy_q    <= tfar_y;
            fz_q    <= tfar_z;
            cmp_a_q <= tnear_x;
            cmp_b_q <= tnear_y;
            step_q  <= 3'd1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            tn_q  <= tn_d;
            tf_q  <= tf_d;
`ifdef RAY_BEHIND_CHECK_EN
            if (step_q == 3'd5) hit_r_q <= cmp_less;
`endif
            if (step_q == LastStep) begin
              step_q    <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              hit_q     <= hit_fin;
              t_entry_q <= tn_q;
              t_exit_q  <= tf_q;
              state_q   <= StDone;
            end else begin
              step_q  <= step_q + 3'd1;
              cmp_a_q <= cmp_a_d;
              cmp_b_q <= cmp_b_d;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign t_entry = t_entry_q;
  assign t_exit  = t_exit_q;
  assign cmp_a   = cmp_a_q;
  assign cmp_b   = cmp_b_q;

endmodule
